hostbus_wb_master: RTL and testbench
====================================

# hostbus_wb_master

Wishbone master side of the Hostbus-Wishbone gateway. Accepts asynchronous read/write strobes from the external host bus, synchronises them into `clk`, and runs one fixed-latency Wishbone access per host strobe on the global `glob_*` bus. It feeds the address-decoding interconnect directly: its `glob_*` outputs drive the interconnect's `glob_*` inputs, and it captures `glob_rdData` for the host.

## Interface
- `DATA_WIDTH`, default 16: host and Wishbone data width.
- `ADDR_WIDTH`, default 16: host and Wishbone address width.
- `WAIT_CYCLES`, default 1: extra strobe cycles per access. Legal range is 0..15.
- `clk`  in  1: single clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `hb_cs_n`  in  1: host chip select, active low, asynchronous to `clk`.
- `hb_rd_n`  in  1: host read strobe, active low, asynchronous.
- `hb_wr_n`  in  1: host write strobe, active low, asynchronous.
- `hb_addr`  in  ADDR_WIDTH: host address. Stable while the host strobe is active.
- `hb_wdata`  in  DATA_WIDTH: host write data. Stable while `hb_wr_n` is low.
- `hb_rdata`  out  DATA_WIDTH: last read result, registered.
- `hb_data_oe`  out  1: host data pad output enable.
- `hb_rdy`  out  1: high when the bridge is ready for or has completed an access.
- `hb_err`  out  1: sticky protocol-error flag.
- `glob_cycle`, `glob_strobe`, `glob_write`, `glob_ack`  out  1 each: Wishbone control to the interconnect.
- `glob_addr`  out  ADDR_WIDTH: Wishbone address.
- `glob_wrData`  out  DATA_WIDTH: Wishbone write data.
- `glob_rdData`  in  DATA_WIDTH: read data returned from the interconnect.

## Operation
**Synchronisation and request detection**
- `hb_cs_n`, `hb_rd_n` and `hb_wr_n` each pass through a 2-FF synchroniser.
- `req_rd` = synced `cs` low AND synced `rd` low AND synced `wr` high. `req_wr` is the same with `rd` and `wr` swapped.
- `req_bad` = synced `cs` low AND synced `rd` low AND synced `wr` low.

**State machine: IDLE, ACCESS, DONE**
- IDLE, on a `req_wr` or `req_rd` rising edge (cycle E):
  - Register `hb_addr`, `hb_wdata` and the direction.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to ACCESS.
- IDLE, on a `req_bad` rising edge:
  - Set `hb_err`. No Wishbone cycle is started. Stay in IDLE.
- ACCESS:
  - `glob_cycle` = `glob_strobe` = 1.
  - `glob_write` = the registered direction.
  - `glob_addr` = the registered address.
  - `glob_wrData` = the registered data on writes, 0 on reads.
  - The counter decrements each cycle. When the counter is 0 (the last cycle):
    - `glob_ack` = 1.
    - On reads, `glob_rdData` is captured into `hb_rdata` at the clock edge ending that cycle.
    - Go to DONE.
- DONE:
  - All `glob_*` outputs are 0.
  - `hb_rdy` = 1.
  - Go to IDLE once `req_rd`, `req_wr` and `req_bad` are all 0 (host strobe released). Stay in DONE otherwise.

**Output rules**
- Outside ACCESS, all `glob_*` outputs are 0. `glob_addr` and `glob_wrData` are zeroed, not held.
- `hb_rdy` = 0 in ACCESS, 1 in IDLE and DONE.
- `hb_data_oe` = 1 only while in DONE with `req_rd` active, so the host samples settled data.
- `hb_rdata` holds its value until the next read completes. Writes do not change it.
- `hb_err` clears only on `rst`.

**Edge cases**
- A strobe released during ACCESS does not abort the access: the access completes, and DONE exits on the next cycle.
- A new strobe edge while in ACCESS or DONE is ignored. Only a fresh edge seen in IDLE starts an access.
- If a direction change occurs without the strobe going inactive, no edge is seen and no new access starts.

## Timing
- **Reset values:** all `glob_*` outputs 0, `hb_rdata` = 0, `hb_data_oe` = 0, `hb_rdy` = 1, `hb_err` = 0, state IDLE, synchronisers 0.
- **Reset handling:** reset applies asynchronously at any point, including mid-ACCESS. The Wishbone cycle drops immediately with no ack.
- **Synchroniser latency:** 2–3 clocks from the host pin to cycle E.
- **ACCESS timing:** ACCESS spans cycles E+1 .. E+1+WAIT_CYCLES. `glob_strobe` is high for WAIT_CYCLES+1 cycles. `glob_ack` is high only in cycle E+1+WAIT_CYCLES.
- **Read data:** `hb_rdata` is valid from cycle E+2+WAIT_CYCLES, the same cycle DONE is entered.
- **Minimum spacing:** the minimum spacing between accesses is WAIT_CYCLES+5 clocks. This covers ACCESS, at least one DONE cycle, the release propagating through the synchroniser, and a new edge arriving in IDLE.

## Test plan
- **Write:** WAIT_CYCLES=1, host writes 0xA5A5 to 0x0005.
  - Required: `glob_strobe`/`glob_cycle`/`glob_write` high for 2 cycles with `glob_addr`=0x0005 and `glob_wrData`=0xA5A5.
  - Required: `glob_ack` high in the 2nd cycle only; `hb_rdy` low for exactly 2 cycles; `hb_rdata` unchanged.
- **Read:** host reads 0x0103 with `glob_rdData` driven to 0x1234.
  - Required: `glob_write`=0, `glob_wrData`=0, `hb_rdata`=0x1234 on entering DONE, `hb_data_oe`=1 until `hb_rd_n` rises.
- **Protocol error:** `hb_rd_n` and `hb_wr_n` both low with `hb_cs_n` low.
  - Required: `hb_err`=1, no `glob_cycle` pulse; a following valid write completes normally with `hb_err` still 1.
- **Early release:** host releases the strobe one cycle into ACCESS.
  - Required: full WAIT_CYCLES+1 strobe, then DONE→IDLE after exactly one cycle.
- **Reset mid-access:** assert `rst` during ACCESS.
  - Required: all `glob_*` outputs 0 in the same cycle, `hb_rdy`=1, no `glob_ack`; the next write after reset completes correctly.
- **Back-to-back reads:** WAIT_CYCLES=0, two reads to 0x00FF then 0x010F.
  - Required: one-cycle strobe with ack each, and `hb_rdata` matches each returned value in order.

Source files
------------

// File: rtl/hostbus_wb_master.sv
// hostbus_wb_master: turns asynchronous host-bus read/write strobes into one
// fixed-latency Wishbone master access each on the global glob_* bus.
module hostbus_wb_master #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hb_cs_n,
    input  logic                  hb_rd_n,
    input  logic                  hb_wr_n,
    input  logic [ADDR_WIDTH-1:0] hb_addr,
    input  logic [DATA_WIDTH-1:0] hb_wdata,
    output logic [DATA_WIDTH-1:0] hb_rdata,
    output logic                  hb_data_oe,
    output logic                  hb_rdy,
    output logic                  hb_err,
    output logic                  glob_cycle,
    output logic                  glob_strobe,
    output logic                  glob_write,
    output logic                  glob_ack,
    output logic [ADDR_WIDTH-1:0] glob_addr,
    output logic [DATA_WIDTH-1:0] glob_wrData,
    input  logic [DATA_WIDTH-1:0] glob_rdData
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]            r_cs_sync;
    logic [1:0]            r_rd_sync;
    logic [1:0]            r_wr_sync;
    logic                  r_req_rd_d;
    logic                  r_req_wr_d;
    logic                  r_req_bad_d;
    logic [1:0]            r_state;
    logic [3:0]            r_wait;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic                  w_cs;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_req_rd;
    logic                  w_req_wr;
    logic                  w_req_bad;
    logic                  w_req_none;
    logic                  w_start;
    logic                  w_bad_edge;
    logic                  w_access;
    logic                  w_done;
    logic                  w_last;

    // Two-flop synchronisers; bit 0 is the metastability stage, bit 1 is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_sync <= '0;
            r_rd_sync <= '0;
            r_wr_sync <= '0;
        end else begin
            r_cs_sync <= {r_cs_sync[0], hb_cs_n};
            r_rd_sync <= {r_rd_sync[0], hb_rd_n};
            r_wr_sync <= {r_wr_sync[0], hb_wr_n};
        end
    end

    assign w_cs       = ~r_cs_sync[1];
    assign w_rd       = ~r_rd_sync[1];
    assign w_wr       = ~r_wr_sync[1];
    assign w_req_rd   = w_cs & w_rd & ~w_wr;
    assign w_req_wr   = w_cs & w_wr & ~w_rd;
    assign w_req_bad  = w_cs & w_rd & w_wr;
    assign w_req_none = ~(w_req_rd | w_req_wr | w_req_bad);

    // Previous-request flags reset high: the all-zero synchroniser state right
    // after reset decodes as a bad request and must not count as a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_rd_d  <= 1'b1;
            r_req_wr_d  <= 1'b1;
            r_req_bad_d <= 1'b1;
        end else begin
            r_req_rd_d  <= w_req_rd;
            r_req_wr_d  <= w_req_wr;
            r_req_bad_d <= w_req_bad;
        end
    end

    assign w_start    = (w_req_rd & ~r_req_rd_d) | (w_req_wr & ~r_req_wr_d);
    assign w_bad_edge = w_req_bad & ~r_req_bad_d;
    assign w_access   = (r_state == ST_ACCESS);
    assign w_done     = (r_state == ST_DONE);
    assign w_last     = w_access & (r_wait == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wait  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_ACCESS;
                        r_wait  <= WAIT_LOAD;
                    end
                end
                ST_ACCESS: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (w_req_none) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == ST_IDLE) && w_start) begin
            r_write <= w_req_wr;
            r_addr  <= hb_addr;
            r_wdata <= hb_wdata;
        end
    end

    // Read data is taken at the edge that ends the acked cycle, so it is
    // already valid in the first DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_last && !r_write) begin
            r_rdata <= glob_rdData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && !w_start && w_bad_edge) begin
            r_err <= 1'b1;
        end
    end

    assign glob_cycle  = w_access;
    assign glob_strobe = w_access;
    assign glob_write  = w_access & r_write;
    assign glob_ack    = w_last;
    assign glob_addr   = w_access ? r_addr : '0;
    assign glob_wrData = (w_access && r_write) ? r_wdata : '0;

    assign hb_rdata    = r_rdata;
    assign hb_data_oe  = w_done & w_req_rd;
    assign hb_rdy      = ~w_access;
    assign hb_err      = r_err;

endmodule

// File: tb/tb_hostbus_wb_master.sv
// Self-checking bench for hostbus_wb_master: two instances (WAIT_CYCLES 1 and 0)
// share one host bus and are compared every cycle against a cycle-index model.
module tb_hostbus_wb_master;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              hbCsN   = 1'b1;
    logic              hbRdN   = 1'b1;
    logic              hbWrN   = 1'b1;
    logic [15:0]       hbAddr  = '0;
    logic [15:0]       hbWdata = '0;
    logic [15:0]       rdData  = '0;

    logic [1:0][15:0]  hbRdata;
    logic [1:0][15:0]  gAddr;
    logic [1:0][15:0]  gWrData;
    logic [1:0]        dataOe;
    logic [1:0]        rdy;
    logic [1:0]        err;
    logic [1:0]        gCyc;
    logic [1:0]        gStb;
    logic [1:0]        gWe;
    logic [1:0]        gAck;

    int checks   = 0;
    int failures = 0;

    // Model: synchronised pin history plus, per instance, the cycle window of
    // the current access and whether the bridge still waits for strobe release.
    logic [2:0]  syncA;
    logic [2:0]  syncB;
    logic [2:0]  prevReq;
    int          cyc;
    int          accStart [2];
    int          accEnd   [2];
    bit          holding  [2];
    bit          mWrite   [2];
    bit          mErr     [2];
    logic [15:0] mAddr    [2];
    logic [15:0] mData    [2];
    logic [15:0] mRdata   [2];

    int          stbCnt   [2];
    int          ackCnt   [2];
    int          rdyLowCnt[2];
    int          weCnt    [2];
    logic [15:0] lastAddr [2];
    logic [15:0] lastWdata[2];
    int          baseStb  [2];
    int          baseAck  [2];
    int          baseRdy  [2];
    int          baseWe   [2];

    always #5 clk = ~clk;

    hostbus_wb_master #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .WAIT_CYCLES(1)) dutWait1 (
        .clk(clk), .rst(rst), .hb_cs_n(hbCsN), .hb_rd_n(hbRdN), .hb_wr_n(hbWrN),
        .hb_addr(hbAddr), .hb_wdata(hbWdata), .hb_rdata(hbRdata[0]),
        .hb_data_oe(dataOe[0]), .hb_rdy(rdy[0]), .hb_err(err[0]),
        .glob_cycle(gCyc[0]), .glob_strobe(gStb[0]), .glob_write(gWe[0]),
        .glob_ack(gAck[0]), .glob_addr(gAddr[0]), .glob_wrData(gWrData[0]),
        .glob_rdData(rdData)
    );

    hostbus_wb_master #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .WAIT_CYCLES(0)) dutWait0 (
        .clk(clk), .rst(rst), .hb_cs_n(hbCsN), .hb_rd_n(hbRdN), .hb_wr_n(hbWrN),
        .hb_addr(hbAddr), .hb_wdata(hbWdata), .hb_rdata(hbRdata[1]),
        .hb_data_oe(dataOe[1]), .hb_rdy(rdy[1]), .hb_err(err[1]),
        .glob_cycle(gCyc[1]), .glob_strobe(gStb[1]), .glob_write(gWe[1]),
        .glob_ack(gAck[1]), .glob_addr(gAddr[1]), .glob_wrData(gWrData[1]),
        .glob_rdData(rdData)
    );

    function automatic int waitOf(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    // Returns {read, write, bad} decoded from a synchronised {cs_n, rd_n, wr_n}.
    function automatic logic [2:0] decodeReq(input logic [2:0] s);
        logic [2:0] r;
        r[2] = !s[2] && !s[1] &&  s[0];
        r[1] = !s[2] &&  s[1] && !s[0];
        r[0] = !s[2] && !s[1] && !s[0];
        return r;
    endfunction

    // Requests already present when reset is applied never count as new edges.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            syncA   <= '0;
            syncB   <= '0;
            prevReq <= 3'b111;
            cyc     <= 0;
            for (int i = 0; i < 2; i++) begin
                accStart[i] <= -100;
                accEnd[i]   <= -100;
                holding[i]  <= 1'b0;
                mWrite[i]   <= 1'b0;
                mErr[i]     <= 1'b0;
                mAddr[i]    <= '0;
                mData[i]    <= '0;
                mRdata[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (cyc >= accStart[i] && cyc <= accEnd[i]) begin
                    if (cyc == accEnd[i]) begin
                        if (!mWrite[i]) mRdata[i] <= rdData;
                        holding[i] <= 1'b1;
                    end
                end else if (holding[i]) begin
                    if (decodeReq(syncB) == 3'b000) holding[i] <= 1'b0;
                end else if ((decodeReq(syncB) & ~prevReq & 3'b110) != 3'b000) begin
                    accStart[i] <= cyc + 1;
                    accEnd[i]   <= cyc + 1 + waitOf(i);
                    mWrite[i]   <= decodeReq(syncB) == 3'b010;
                    mAddr[i]    <= hbAddr;
                    mData[i]    <= hbWdata;
                end else if (decodeReq(syncB) == 3'b001 && !prevReq[0]) begin
                    mErr[i] <= 1'b1;
                end
            end
            prevReq <= decodeReq(syncB);
            syncB   <= syncA;
            syncA   <= {hbCsN, hbRdN, hbWrN};
            cyc     <= cyc + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic compareDut(input int i);
        bit          acc;
        bit          done;
        logic [2:0]  req;
        acc  = (cyc >= accStart[i]) && (cyc <= accEnd[i]);
        done = holding[i] && !acc;
        req  = decodeReq(syncB);
        checkOutput($sformatf("glob_cycle[%0d]", i),  32'(gCyc[i]), 32'(acc));
        checkOutput($sformatf("glob_strobe[%0d]", i), 32'(gStb[i]), 32'(acc));
        checkOutput($sformatf("glob_write[%0d]", i),  32'(gWe[i]),  32'(acc && mWrite[i]));
        checkOutput($sformatf("glob_ack[%0d]", i),    32'(gAck[i]), 32'(acc && cyc == accEnd[i]));
        checkOutput($sformatf("glob_addr[%0d]", i),   32'(gAddr[i]), acc ? 32'(mAddr[i]) : 32'd0);
        checkOutput($sformatf("glob_wrData[%0d]", i), 32'(gWrData[i]), (acc && mWrite[i]) ? 32'(mData[i]) : 32'd0);
        checkOutput($sformatf("hb_rdy[%0d]", i),      32'(rdy[i]), 32'(!acc));
        checkOutput($sformatf("hb_data_oe[%0d]", i),  32'(dataOe[i]), 32'(done && req[2]));
        checkOutput($sformatf("hb_rdata[%0d]", i),    32'(hbRdata[i]), 32'(mRdata[i]));
        checkOutput($sformatf("hb_err[%0d]", i),      32'(err[i]), 32'(mErr[i]));
    endtask

    // Every clock advance goes through here, so the model comparison and the
    // activity counters see every cycle.
    task automatic stepCycle;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            compareDut(i);
            stbCnt[i]    += int'(gStb[i]);
            ackCnt[i]    += int'(gAck[i]);
            rdyLowCnt[i] += int'(!rdy[i]);
            weCnt[i]     += int'(gWe[i]);
            if (gStb[i]) begin
                lastAddr[i]  = gAddr[i];
                lastWdata[i] = gWrData[i];
            end
        end
    endtask

    task automatic applyStimulus(input logic csN, input logic rdN, input logic wrN,
                                 input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] rdVal, input int cycles);
        hbAddr  = addr;
        hbWdata = wdata;
        rdData  = rdVal;
        hbCsN   = csN;
        hbRdN   = rdN;
        hbWrN   = wrN;
        for (int n = 0; n < cycles; n++) stepCycle();
    endtask

    task automatic snapCounts;
        for (int i = 0; i < 2; i++) begin
            baseStb[i] = stbCnt[i];
            baseAck[i] = ackCnt[i];
            baseRdy[i] = rdyLowCnt[i];
            baseWe[i]  = weCnt[i];
        end
    endtask

    task automatic checkCounts(input string tag, input int i, input int stb, input int ack, input int we);
        checkOutput($sformatf("%s strobeCycles[%0d]", tag, i), 32'(stbCnt[i] - baseStb[i]), 32'(stb));
        checkOutput($sformatf("%s ackCycles[%0d]", tag, i),    32'(ackCnt[i] - baseAck[i]), 32'(ack));
        checkOutput($sformatf("%s rdyLowCycles[%0d]", tag, i), 32'(rdyLowCnt[i] - baseRdy[i]), 32'(stb));
        checkOutput($sformatf("%s writeCycles[%0d]", tag, i),  32'(weCnt[i] - baseWe[i]), 32'(we));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            stbCnt[i] = 0; ackCnt[i] = 0; rdyLowCnt[i] = 0; weCnt[i] = 0;
            lastAddr[i] = '0; lastWdata[i] = '0;
        end

        // Reset state
        stepCycle();
        stepCycle();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("reset hb_rdy[%0d]", i), 32'(rdy[i]), 32'd1);
            checkOutput($sformatf("reset hb_err[%0d]", i), 32'(err[i]), 32'd0);
            checkOutput($sformatf("reset glob_cycle[%0d]", i), 32'(gCyc[i]), 32'd0);
            checkOutput($sformatf("reset hb_rdata[%0d]", i), 32'(hbRdata[i]), 32'd0);
        end
        rst = 1'b0;
        applyStimulus(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 4);

        // Write 0xA5A5 to 0x0005
        snapCounts();
        applyStimulus(0, 1, 0, 16'h0005, 16'hA5A5, 16'h0000, 8);
        applyStimulus(1, 1, 1, 16'h0005, 16'hA5A5, 16'h0000, 6);
        checkCounts("write", 0, 2, 1, 2);
        checkCounts("write", 1, 1, 1, 1);
        checkOutput("write addr", 32'(lastAddr[0]), 32'h0005);
        checkOutput("write data", 32'(lastWdata[0]), 32'hA5A5);
        checkOutput("write keeps hb_rdata", 32'(hbRdata[0]), 32'h0000);

        // Read 0x0103 returning 0x1234; write-data pins deliberately nonzero
        snapCounts();
        applyStimulus(0, 0, 1, 16'h0103, 16'hFFFF, 16'h1234, 8);
        checkOutput("read hb_rdata[0]", 32'(hbRdata[0]), 32'h1234);
        checkOutput("read hb_rdata[1]", 32'(hbRdata[1]), 32'h1234);
        checkOutput("read data_oe while held", 32'(dataOe[0]), 32'd1);
        applyStimulus(1, 1, 1, 16'h0103, 16'hFFFF, 16'h1234, 6);
        checkOutput("read data_oe after release", 32'(dataOe[0]), 32'd0);
        checkCounts("read", 0, 2, 1, 0);
        checkOutput("read addr", 32'(lastAddr[0]), 32'h0103);
        checkOutput("read wrData", 32'(lastWdata[0]), 32'h0000);

        // Protocol error, then a normal write
        snapCounts();
        applyStimulus(0, 0, 0, 16'h0040, 16'h1111, 16'h0000, 6);
        applyStimulus(1, 1, 1, 16'h0040, 16'h1111, 16'h0000, 4);
        checkOutput("bad hb_err[0]", 32'(err[0]), 32'd1);
        checkOutput("bad hb_err[1]", 32'(err[1]), 32'd1);
        checkCounts("bad", 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 16'h0040, 16'h1111, 16'h0000, 8);
        applyStimulus(1, 1, 1, 16'h0040, 16'h1111, 16'h0000, 6);
        checkCounts("post-bad write", 0, 2, 1, 2);
        checkOutput("post-bad hb_err", 32'(err[0]), 32'd1);
        checkOutput("post-bad hb_rdata", 32'(hbRdata[0]), 32'h1234);

        // Early release one cycle into ACCESS
        snapCounts();
        applyStimulus(0, 0, 1, 16'h0022, 16'h0000, 16'hBEEF, 3);
        applyStimulus(1, 1, 1, 16'h0022, 16'h0000, 16'hBEEF, 8);
        checkCounts("early", 0, 2, 1, 0);
        checkCounts("early", 1, 1, 1, 0);
        checkOutput("early hb_rdata", 32'(hbRdata[0]), 32'hBEEF);

        // Reset in the first ACCESS cycle
        snapCounts();
        applyStimulus(0, 1, 0, 16'h0007, 16'h0055, 16'h0000, 1);
        for (int n = 0; n < 20 && !gStb[0]; n++) stepCycle();
        checkOutput("reset wait strobe", 32'(gStb[0]), 32'd1);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("midrst glob_cycle[%0d]", i), 32'(gCyc[i]), 32'd0);
            checkOutput($sformatf("midrst glob_strobe[%0d]", i), 32'(gStb[i]), 32'd0);
            checkOutput($sformatf("midrst glob_ack[%0d]", i), 32'(gAck[i]), 32'd0);
            checkOutput($sformatf("midrst glob_addr[%0d]", i), 32'(gAddr[i]), 32'd0);
            checkOutput($sformatf("midrst hb_rdy[%0d]", i), 32'(rdy[i]), 32'd1);
        end
        applyStimulus(1, 1, 1, 16'h0007, 16'h0055, 16'h0000, 2);
        checkOutput("midrst ackCycles[0]", 32'(ackCnt[0] - baseAck[0]), 32'd0);
        rst = 1'b0;
        applyStimulus(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 3);
        snapCounts();
        applyStimulus(0, 1, 0, 16'h0009, 16'h0077, 16'h0000, 8);
        applyStimulus(1, 1, 1, 16'h0009, 16'h0077, 16'h0000, 6);
        checkCounts("after reset write", 0, 2, 1, 2);
        checkOutput("after reset addr", 32'(lastAddr[0]), 32'h0009);
        checkOutput("after reset data", 32'(lastWdata[0]), 32'h0077);
        checkOutput("after reset hb_err", 32'(err[0]), 32'd0);
        checkOutput("after reset hb_rdata", 32'(hbRdata[0]), 32'h0000);

        // Back-to-back reads on the zero-wait instance
        snapCounts();
        applyStimulus(0, 0, 1, 16'h00FF, 16'h0000, 16'h0A0A, 5);
        checkOutput("b2b first hb_rdata[1]", 32'(hbRdata[1]), 32'h0A0A);
        checkOutput("b2b first addr[1]", 32'(lastAddr[1]), 32'h00FF);
        applyStimulus(1, 1, 1, 16'h00FF, 16'h0000, 16'h0A0A, 5);
        checkCounts("b2b first", 1, 1, 1, 0);
        snapCounts();
        applyStimulus(0, 0, 1, 16'h010F, 16'h0000, 16'h5A5A, 5);
        checkOutput("b2b second hb_rdata[1]", 32'(hbRdata[1]), 32'h5A5A);
        checkOutput("b2b second addr[1]", 32'(lastAddr[1]), 32'h010F);
        applyStimulus(1, 1, 1, 16'h010F, 16'h0000, 16'h5A5A, 5);
        checkCounts("b2b second", 1, 1, 1, 0);
        checkOutput("b2b second hb_rdata[0]", 32'(hbRdata[0]), 32'h5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
